multicycle_controlunit: RTL and testbench

- Moore FSM controller for the multi-cycle MIPS32 datapath.
- Replaces the single-cycle combinational decoder; the instruction set is unchanged: R-type, lw, sw, beq, j, jal, addi, ori.
- Sequences each instruction over 3–5 cycles and drives one shared memory, the IR, the PC and a single ALU.
- Adds generalised opcode width/values, memory wait-state handshake, illegal-opcode trap, and an instruction-complete strobe.

---
 rtl/multicycle_controlunit_if.sv | 41 ++++
 rtl/multicycle_controlunit.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_controlunit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_controlunit_if.sv
// Control bundle between the multi-cycle MIPS32 control unit and its datapath.
//   OpCode, mem_ready         : datapath -> controller (IR[31:26], memory handshake)
//   PCWrite ... illegal_op    : controller -> datapath (datapath control strobes/selects)
//   state                     : controller current state, for debug
// Modports: master = control unit side, slave = datapath side.
interface multicycle_controlunit_if #(
    parameter int OP_WIDTH = 6
);
    logic [OP_WIDTH-1:0] OpCode;
    logic                mem_ready;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic [1:0]          MemtoReg;
    logic [1:0]          RegDst;
    logic [1:0]          AluOp;
    logic                AluSrcA;
    logic [1:0]          AluSrcB;
    logic [1:0]          PCSource;
    logic                RegWrite;
    logic                instr_done;
    logic                illegal_op;
    logic [3:0]          state;

    modport master (
        input  OpCode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, AluOp, AluSrcA, AluSrcB, PCSource,
               RegWrite, instr_done, illegal_op, state
    );

    modport slave (
        output OpCode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, AluOp, AluSrcA, AluSrcB, PCSource,
               RegWrite, instr_done, illegal_op, state
    );
endinterface

// File: rtl/multicycle_controlunit.sv
// Moore FSM control unit for the multi-cycle MIPS32 datapath (R-type, lw, sw,
// beq, j, jal, addi, ori). Each instruction takes 3-5 cycles plus one cycle per
// memory wait state.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; forces FETCH and all-zero outputs
//   bus   : multicycle_controlunit_if.master (opcode/handshake in, controls out)
//
// state  | meaning
// -------+--------------------------------------------------------------
// FETCH  | read instruction at PC, PC <= PC+4 and IR load once mem_ready
// DECODE | latch opcode, precompute branch target, dispatch / trap illegal
// MEMADR | ALUOut <= A + signext(imm)
// MEMRD  | read data memory at ALUOut, wait for mem_ready
// MEMWB  | write MDR to rt
// MEMWR  | write data memory at ALUOut, wait for mem_ready
// EXEC   | R-type ALU operation (funct)
// ALUWB  | write ALUOut to rd
// BRANCH | compare A-B, load branch target if zero
// JUMP   | load jump target
// IEXEC  | immediate ALU operation (add or or)
// IWB    | write ALUOut to rt
// JAL    | load jump target and write old PC (PC+4) to $31
module multicycle_controlunit #(
    parameter int                  OP_WIDTH = 6,
    parameter logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(0),
    parameter logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(35),
    parameter logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(43),
    parameter logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(4),
    parameter logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(2),
    parameter logic [OP_WIDTH-1:0] OP_JAL   = OP_WIDTH'(3),
    parameter logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(8),
    parameter logic [OP_WIDTH-1:0] OP_ORI   = OP_WIDTH'(13)
) (
    input logic                      clk,
    input logic                      reset,
    multicycle_controlunit_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    state_t              state_q, state_d;
    logic [OP_WIDTH-1:0] op_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            // op_q is only consulted after DECODE, so later OpCode changes are ignored
            if (state_q == S_DECODE) op_q <= bus.OpCode;
        end
    end

    assign bus.state = reset ? 4'd0 : state_q;

    always_comb begin
        state_d         = S_FETCH;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 2'b00;
        bus.RegDst      = 2'b00;
        bus.AluOp       = 2'b00;
        bus.AluSrcA     = 1'b0;
        bus.AluSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.RegWrite    = 1'b0;
        bus.instr_done  = 1'b0;
        bus.illegal_op  = 1'b0;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.AluSrcB = 2'b01;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                    state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    bus.AluSrcB = 2'b11;
                    case (bus.OpCode)
                        OP_LW, OP_SW:   state_d = S_MEMADR;
                        OP_RTYPE:       state_d = S_EXEC;
                        OP_BEQ:         state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        OP_JAL:         state_d = S_JAL;
                        OP_ADDI, OP_ORI: state_d = S_IEXEC;
                        default: begin
                            bus.illegal_op = 1'b1;
                            bus.instr_done = 1'b1;
                            state_d        = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluSrcB = 2'b10;
                    state_d     = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                    state_d     = bus.mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    bus.MemtoReg   = 2'b01;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWrite   = 1'b1;
                    bus.IorD       = 1'b1;
                    bus.instr_done = bus.mem_ready;
                    state_d        = bus.mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluOp   = 2'b10;
                    state_d     = S_ALUWB;
                end
                S_ALUWB: begin
                    bus.RegDst     = 2'b01;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    bus.AluSrcA     = 1'b1;
                    bus.AluOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                    bus.instr_done  = 1'b1;
                end
                S_JUMP: begin
                    bus.PCWrite    = 1'b1;
                    bus.PCSource   = 2'b10;
                    bus.instr_done = 1'b1;
                end
                S_JAL: begin
                    // PC already holds PC+4, so the link value is the current PC
                    bus.PCWrite    = 1'b1;
                    bus.PCSource   = 2'b10;
                    bus.RegWrite   = 1'b1;
                    bus.RegDst     = 2'b10;
                    bus.MemtoReg   = 2'b10;
                    bus.instr_done = 1'b1;
                end
                S_IEXEC: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluSrcB = 2'b10;
                    bus.AluOp   = (op_q == OP_ORI) ? 2'b11 : 2'b00;
                    state_d     = S_IWB;
                end
                S_IWB: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Self-checking bench for multicycle_controlunit: each instruction is expanded
// into a cycle-by-cycle plan of expected states, and every cycle's state and
// control word are compared against the output table for that state.
module tb_multicycle_controlunit;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4,
                   MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9,
                   IEXEC = 10, IWB = 11, JAL = 12;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    multicycle_controlunit_if #(.OP_WIDTH(6)) bus ();

    multicycle_controlunit #(.OP_WIDTH(6)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    logic [19:0] ctrl_obs;
    assign ctrl_obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                       bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                       bus.AluOp, bus.AluSrcA, bus.AluSrcB, bus.PCSource,
                       bus.RegWrite, bus.instr_done, bus.illegal_op};

    function automatic bit is_legal(logic [5:0] op);
        return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 ||
               op == 6'd2 || op == 6'd3 || op == 6'd8 || op == 6'd13;
    endfunction

    // Expected control word for one cycle in the given state.
    function automatic logic [19:0] exp_ctrl(int st, bit rdy, logic [5:0] op);
        logic       pcw, pcwc, iord, mr, mw, irw, asa, rw, done, ill;
        logic [1:0] m2r, rdst, aop, asb, pcs;
        {pcw, pcwc, iord, mr, mw, irw, asa, rw, done, ill} = '0;
        {m2r, rdst, aop, asb, pcs} = '0;
        case (st)
            FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            DECODE: begin asb = 2'b11; ill = !is_legal(op); done = !is_legal(op); end
            MEMADR: begin asa = 1; asb = 2'b10; end
            MEMRD:  begin mr = 1; iord = 1; end
            MEMWB:  begin m2r = 2'b01; rw = 1; done = 1; end
            MEMWR:  begin mw = 1; iord = 1; done = rdy; end
            EXEC:   begin asa = 1; aop = 2'b10; end
            ALUWB:  begin rdst = 2'b01; rw = 1; done = 1; end
            BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            JUMP:   begin pcw = 1; pcs = 2'b10; done = 1; end
            JAL:    begin pcw = 1; pcs = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; done = 1; end
            IEXEC:  begin asa = 1; asb = 2'b10; aop = (op == 6'd13) ? 2'b11 : 2'b00; end
            IWB:    begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, aop, asa, asb, pcs, rw, done, ill};
    endfunction

    task automatic check(string tag, logic [19:0] obs, logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold reset for n cycles; state and every control must read 0.
    task automatic do_reset(int n, bit rdy);
        reset         = 1'b1;
        bus.mem_ready = rdy;
        for (int i = 0; i < n; i++) begin
            bus.OpCode = 6'($urandom);
            @(negedge clk);
            check("reset_state", 20'(bus.state), 20'd0);
            check("reset_ctrl", ctrl_obs, 20'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // Run one instruction with fw FETCH wait cycles and mw data-memory wait
    // cycles; stop_after >= 0 abandons it after that many cycles.
    task automatic run_instr(logic [5:0] op, int fw, int mw, int stop_after);
        int st[$];
        bit rd[$];
        int n;
        int dones;
        for (int i = 0; i < fw; i++) begin st.push_back(FETCH); rd.push_back(1'b0); end
        st.push_back(FETCH);  rd.push_back(1'b1);
        st.push_back(DECODE); rd.push_back(1'($urandom));
        case (op)
            6'd35: begin
                st.push_back(MEMADR); rd.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin st.push_back(MEMRD); rd.push_back(1'b0); end
                st.push_back(MEMRD); rd.push_back(1'b1);
                st.push_back(MEMWB); rd.push_back(1'($urandom));
            end
            6'd43: begin
                st.push_back(MEMADR); rd.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin st.push_back(MEMWR); rd.push_back(1'b0); end
                st.push_back(MEMWR); rd.push_back(1'b1);
            end
            6'd0:  begin st.push_back(EXEC); rd.push_back(1'($urandom));
                         st.push_back(ALUWB); rd.push_back(1'($urandom)); end
            6'd4:  begin st.push_back(BRANCH); rd.push_back(1'($urandom)); end
            6'd2:  begin st.push_back(JUMP); rd.push_back(1'($urandom)); end
            6'd3:  begin st.push_back(JAL); rd.push_back(1'($urandom)); end
            6'd8, 6'd13: begin
                st.push_back(IEXEC); rd.push_back(1'($urandom));
                st.push_back(IWB); rd.push_back(1'($urandom));
            end
            default: ;
        endcase
        n     = (stop_after < 0) ? st.size() : stop_after;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = rd[i];
            bus.OpCode    = (st[i] == DECODE) ? op : 6'($urandom);
            @(negedge clk);
            check($sformatf("state op=%0d cyc=%0d", op, i), 20'(bus.state), 20'(st[i]));
            check($sformatf("ctrl op=%0d cyc=%0d st=%0d", op, i, st[i]), ctrl_obs,
                  exp_ctrl(st[i], rd[i], op));
            if (bus.instr_done) dones++;
            @(posedge clk);
            #1;
        end
        if (stop_after < 0)
            check($sformatf("done_count op=%0d", op), 20'(dones), 20'd1);
    endtask

    initial begin
        logic [5:0] legal_ops [8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd3, 6'd8, 6'd13};
        logic [5:0] op;
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.OpCode    = 6'd0;

        do_reset(2, 1'b1);
        run_instr(6'd0, 0, 0, -1);
        run_instr(6'd35, 0, 0, -1);
        run_instr(6'd43, 0, 3, -1);
        run_instr(6'd4, 0, 0, -1);
        run_instr(6'd2, 0, 0, -1);
        run_instr(6'd3, 0, 0, -1);
        run_instr(6'd8, 0, 0, -1);
        run_instr(6'd13, 0, 0, -1);
        run_instr(6'd20, 0, 0, -1);
        // Two FETCH waits, then reset during the second MEMRD wait cycle.
        run_instr(6'd35, 2, 3, 6);
        do_reset(1, 1'b0);
        run_instr(6'd0, 1, 0, -1);
        // Reset in the middle of a stalled store.
        run_instr(6'd43, 0, 4, 4);
        do_reset(1, 1'b0);
        run_instr(6'd4, 0, 0, -1);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 7)];
            end
            if ($urandom_range(0, 15) == 0) begin
                run_instr(op, $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(1, 4));
                do_reset($urandom_range(1, 2), 1'($urandom));
            end else begin
                run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
